// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a CPU test harness.
// - 64x32 RAM at byte addresses 0..255 (word index DataAdr[7:2]).
// - Verdict FSM (RUN/PASS/FAIL) driven by stores to 96 and 100.
// - Cycle and store counters, both saturating.
// - Optional 4-entry store trace FIFO, built only when DMEM_TRACE_EN is defined;
//   without it the trace outputs are tied low and TraceReady is ignored.
module dmem_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic        Pass,
  output logic [31:0] CycleCount,
  output logic [15:0] WriteCount,
  output logic        TraceValid,
  input  logic        TraceReady,
  output logic [31:0] TraceAdr,
  output logic [31:0] TraceData,
  output logic        TraceOvf
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam logic [31:0] ADR_PROGRESS = 32'd96;
  localparam logic [31:0] ADR_VERDICT  = 32'd100;
  localparam logic [31:0] PASS_VALUE   = 32'd7;

  // Only the first 256 bytes are backed by RAM.
  logic       in_range;
  logic [5:0] word_idx;

  assign in_range = (DataAdr[31:8] == 24'd0);
  assign word_idx = DataAdr[7:2];

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [31:0] ram_mem [64];

  // Store port: a store coincident with reset is suppressed.
  // NOTE: RAM contents are deliberately not reset; reset must leave prior data readable.
  always_ff @(posedge clk) begin
    if (!reset && MemWrite && in_range) begin
      ram_mem[word_idx] <= WriteData;
    end
  end

  // Combinational read port; out-of-range addresses read as zero.
  assign ReadData = in_range ? ram_mem[word_idx] : 32'd0;

  // ---------------------------------------------------------------------------
  // Verdict FSM and counters
  // ---------------------------------------------------------------------------
  state_e      state_q,     state_d;
  logic        done_q,      done_d;
  logic        pass_q,      pass_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] write_cnt_q, write_cnt_d;

  // Next-state and counter update: the verdict is decided by the first store
  // that is not a progress write to 96.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    write_cnt_d = write_cnt_q;

    if (state_q == ST_RUN) begin
      if (cycle_cnt_q != 32'hFFFF_FFFF) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (MemWrite) begin
        if (DataAdr == ADR_VERDICT) begin
          state_d = (WriteData == PASS_VALUE) ? ST_PASS : ST_FAIL;
        end else if (DataAdr != ADR_PROGRESS) begin
          state_d = ST_FAIL;
        end
      end
    end

    if (MemWrite && (write_cnt_q != 16'hFFFF)) write_cnt_d = write_cnt_q + 16'd1;

    // Verdict outputs are registered from the next state so they rise the
    // cycle after the deciding store.
    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
  end

  // State, verdict and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= ST_RUN;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      cycle_cnt_q <= 32'd0;
      write_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      cycle_cnt_q <= cycle_cnt_d;
      write_cnt_q <= write_cnt_d;
    end
  end

  assign Done       = done_q;
  assign Pass       = pass_q;
  assign CycleCount = cycle_cnt_q;
  assign WriteCount = write_cnt_q;

  // ---------------------------------------------------------------------------
  // Trace FIFO
  // ---------------------------------------------------------------------------
`ifdef DMEM_TRACE_EN
  logic [31:0] fifo_adr  [4];
  logic [31:0] fifo_data [4];

  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q,  count_d;
  logic       ovf_q,    ovf_d;

  logic trace_push;
  logic trace_pop;
  logic trace_full;
  logic push_ok;

  assign trace_full = (count_q == 3'd4);
  assign trace_pop  = (count_q != 3'd0) && TraceReady;
  assign trace_push = MemWrite && (state_q == ST_RUN);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = trace_push && (!trace_full || trace_pop);

  // Pointer, occupancy and overflow update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok)   wr_ptr_d = wr_ptr_q + 2'd1;
    if (trace_pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push_ok && !trace_pop)      count_d = count_q + 3'd1;
    else if (!push_ok && trace_pop) count_d = count_q - 3'd1;
    if (trace_push && !push_ok)     ovf_d   = 1'b1;
  end

  // FIFO control registers; reset empties the FIFO and clears the sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage write; entries are qualified by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      fifo_adr[wr_ptr_q]  <= DataAdr;
      fifo_data[wr_ptr_q] <= WriteData;
    end
  end

  assign TraceValid = (count_q != 3'd0);
  assign TraceAdr   = fifo_adr[rd_ptr_q];
  assign TraceData  = fifo_data[rd_ptr_q];
  assign TraceOvf   = ovf_q;
`else
  // Trace disabled: outputs tied low, TraceReady intentionally unused.
  logic trace_ready_unused;

  assign trace_ready_unused = TraceReady;
  assign TraceValid         = 1'b0;
  assign TraceAdr           = 32'd0;
  assign TraceData          = 32'd0;
  assign TraceOvf           = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver updates a queue/array
// reference model and pushes expected per-cycle outputs and expected trace
// entries; a monitor on the falling edge pops and compares.
module tb_dmem_responder;

`ifdef DMEM_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadData;
  logic        Done;
  logic        Pass;
  logic [31:0] CycleCount;
  logic [15:0] WriteCount;
  logic        TraceValid;
  logic        TraceReady = 1'b0;
  logic [31:0] TraceAdr;
  logic [31:0] TraceData;
  logic        TraceOvf;

  dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Done       (Done),
    .Pass       (Pass),
    .CycleCount (CycleCount),
    .WriteCount (WriteCount),
    .TraceValid (TraceValid),
    .TraceReady (TraceReady),
    .TraceAdr   (TraceAdr),
    .TraceData  (TraceData),
    .TraceOvf   (TraceOvf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          done;
    bit          pass;
    logic [31:0] cyc;
    logic [15:0] wc;
    bit          rd_known;
    logic [31:0] rd;
    bit          tvalid;
    bit          tovf;
  } snap_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } entry_t;

  typedef enum {V_RUN, V_PASS, V_FAIL} verdict_e;

  snap_t  exp_q[$];
  entry_t trace_sb[$];   // entries expected to leave the DUT, in order
  entry_t mdl_fifo[$];   // model FIFO occupancy

  verdict_e    m_verdict = V_RUN;
  longint      m_cyc = 0;
  int          m_wc = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_ram [64];
  bit          m_ram_ok [64];
  bit          model_known = 1'b0;
  bit          clear_sb = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic step(input bit rst, input bit mw, input logic [31:0] adr,
                      input logic [31:0] wd, input bit rdy);
    bit pop, full;
    if (rst) begin
      m_verdict = V_RUN;
      m_cyc = 0;
      m_wc = 0;
      m_ovf = 1'b0;
      mdl_fifo.delete();
      clear_sb = 1'b1;
      model_known = 1'b1;
      return;
    end
    if (mw) begin
      if (m_wc < 65535) m_wc++;
      if (adr < 256) begin
        m_ram[adr[7:2]] = wd;
        m_ram_ok[adr[7:2]] = 1'b1;
      end
    end
    full = (mdl_fifo.size() == 4);
    pop  = (mdl_fifo.size() != 0) && rdy;
    if (pop) void'(mdl_fifo.pop_front());
    if (TRACE_EN && mw && m_verdict == V_RUN) begin
      if (full && !pop) m_ovf = 1'b1;
      else begin
        mdl_fifo.push_back('{adr, wd});
        trace_sb.push_back('{adr, wd});
      end
    end
    if (m_verdict == V_RUN) begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (mw) begin
        if (adr == 100) m_verdict = (wd == 7) ? V_PASS : V_FAIL;
        else if (adr != 96) m_verdict = V_FAIL;
      end
    end
  endtask

  // Apply one cycle of inputs, record expected outputs for it, advance the model.
  task automatic drive(input bit rst, input bit mw, input logic [31:0] adr,
                       input logic [31:0] wd, input bit rdy);
    snap_t s;
    @(posedge clk);
    #1;
    if (clear_sb) begin
      trace_sb.delete();
      clear_sb = 1'b0;
    end
    reset      = rst;
    MemWrite   = mw;
    DataAdr    = adr;
    WriteData  = wd;
    TraceReady = rdy;
    if (model_known) begin
      s.done   = (m_verdict != V_RUN);
      s.pass   = (m_verdict == V_PASS);
      s.cyc    = m_cyc[31:0];
      s.wc     = m_wc[15:0];
      s.tvalid = (mdl_fifo.size() != 0);
      s.tovf   = m_ovf;
      if (adr >= 256) begin
        s.rd_known = 1'b1;
        s.rd = 32'd0;
      end else begin
        s.rd_known = m_ram_ok[adr[7:2]];
        s.rd = m_ram[adr[7:2]];
      end
      exp_q.push_back(s);
    end
    step(rst, mw, adr, wd, rdy);
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] wd, input bit rdy);
    drive(1'b0, 1'b1, adr, wd, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, rdy);
  endtask

  task automatic read(input logic [31:0] adr);
    drive(1'b0, 1'b0, adr, 32'd0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Monitor: compares per-cycle outputs and every trace handshake.
  always @(negedge clk) begin
    snap_t  s;
    entry_t e;
    if (exp_q.size() != 0) begin
      s = exp_q.pop_front();
      check("done",        {31'd0, Done},       {31'd0, s.done});
      check("pass",        {31'd0, Pass},       {31'd0, s.pass});
      check("cycle_count", CycleCount,          s.cyc);
      check("write_count", {16'd0, WriteCount}, {16'd0, s.wc});
      check("trace_valid", {31'd0, TraceValid}, {31'd0, s.tvalid});
      check("trace_ovf",   {31'd0, TraceOvf},   {31'd0, s.tovf});
      if (s.rd_known) check("read_data", ReadData, s.rd);
    end
    if (TraceValid === 1'b1 && TraceReady === 1'b1) begin
      if (trace_sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL trace_pop actual=entry 0x%h/0x%h expected=no entry", TraceAdr, TraceData);
      end else begin
        e = trace_sb.pop_front();
        check("trace_adr",  TraceAdr,  e.adr);
        check("trace_data", TraceData, e.data);
      end
    end
  end

  // Watchdog: the stimulus is bounded, this only guards against a stuck run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [31:0] adr, wd;

    // Verdict PASS sequence, trace held (TraceReady=0) then drained.
    do_reset(2);
    store(32'd96, 32'd3, 1'b0);
    store(32'd96, 32'd5, 1'b0);
    store(32'd100, 32'd7, 1'b0);
    idle(4, 1'b0);
    idle(4, 1'b1);

    // RAM: byte offsets ignored, out-of-range reads zero and stores dropped.
    store(32'd40, 32'h0000_DEAD, 1'b1);
    read(32'd40);
    read(32'd41);
    read(32'd43);
    read(32'd300);
    store(32'd300, 32'd1, 1'b0);
    read(32'd40);
    read(32'd44);
    read(32'd255);

    // Store coincident with reset is neither written nor counted.
    drive(1'b1, 1'b1, 32'd40, 32'h0000_BEEF, 1'b0);
    read(32'd40);

    // Verdict FAIL is sticky.
    do_reset(1);
    store(32'd100, 32'd6, 1'b0);
    idle(1, 1'b0);
    store(32'd100, 32'd7, 1'b0);
    idle(2, 1'b1);

    // Trace overflow: five stores with no consumer, then drain.
    do_reset(1);
    for (int i = 0; i < 5; i++) store(32'd96, 32'h100 + i, 1'b0);
    idle(1, 1'b0);
    idle(5, 1'b1);

    // Full FIFO with push and pop in the same cycle: no overflow.
    do_reset(1);
    for (int i = 0; i < 4; i++) store(32'd96, 32'h200 + i, 1'b0);
    store(32'd96, 32'h204, 1'b1);
    idle(1, 1'b0);
    idle(5, 1'b1);

    // Reset after FAIL with two pending trace entries.
    do_reset(1);
    store(32'd96, 32'd1, 1'b0);
    store(32'd52, 32'd2, 1'b0);
    idle(2, 1'b0);
    do_reset(1);
    read(32'd40);
    idle(2, 1'b1);

    // Randomized traffic, biased toward progress stores to keep RUN alive.
    for (int round = 0; round < 30; round++) begin
      do_reset(1);
      for (int c = 0; c < 40; c++) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2, 3: adr = 32'd96;
          4:          adr = 32'd100;
          5:          adr = {24'd0, 8'($urandom)};
          6:          adr = 32'd256 + $urandom_range(0, 1000);
          7:          adr = $urandom;
          default:    adr = 32'd40 + 32'($urandom_range(0, 3));
        endcase
        wd = ($urandom_range(0, 1) == 0) ? 32'd7 : $urandom;
        if ($urandom_range(0, 99) < 2)
          drive(1'b1, $urandom_range(0, 1) == 1, adr, wd, $urandom_range(0, 1) == 1);
        else
          drive(1'b0, $urandom_range(0, 2) != 0, adr, wd, $urandom_range(0, 2) == 0);
      end
      idle(6, 1'b1);
    end

    // Let the monitor consume the last expectations (bounded wait).
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("trace_sb_empty",   32'(trace_sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
